// File: rtl/mac_pkg.sv
// mac_pkg: shared FSM state encoding and protocol constants for the GMII transmit MAC.
package mac_pkg;
  typedef enum logic [2:0] {IDLE, PTR_RD, PTR_WAIT, PREAMBLE, DATA, PAD, FCS, GAP} state_t;
  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE = 8'hD5;
  localparam int MIN_FRAME_LEN = 60;
  localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY = 32'hEDB8_8320;
endpackage

// File: rtl/crc32_d8.sv
// crc32_d8: combinational reflected CRC-32 update consuming one byte per cycle.
module crc32_d8
  import mac_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);
  logic [31:0] c;
  always_comb begin
    c = crc_in ^ {24'h0, data};
    for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    crc_out = c;
  end
endmodule

// File: rtl/mac_tx.sv
// mac_tx: GMII frame transmitter fed by pointer/data FIFOs; adds preamble, SFD, CRC-32 and IFG.
// Define MAC_TX_PAD_EN to zero-pad frames shorter than 60 bytes before the FCS.
module mac_tx
  import mac_pkg::*;
#(
  parameter int IFG = 12,
  parameter int PREAMBLE_LEN = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tx_ptr_fifo_empty,
  output logic        tx_ptr_fifo_rd,
  input  logic [15:0] tx_ptr_fifo_din,
  output logic        tx_data_fifo_rd,
  input  logic [7:0]  tx_data_fifo_din,
  output logic [7:0]  gmii_txd,
  output logic        gmii_tx_en,
  output logic [15:0] tx_frame_cnt
);
  state_t state_q, state_d;
  logic [10:0] cnt_q, cnt_d, dcnt_q, dcnt_d, len_q, len_d, rd_left_q, rd_left_d;
  logic ptr_rd_q, ptr_rd_d, data_rd_q, data_rd_d, en_q, en_d;
  logic [7:0] txd_q, txd_d;
  logic [31:0] crc_q, crc_d, crc_next;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic ptr_unused;
  assign ptr_unused = ^tx_ptr_fifo_din[15:11];
  crc32_d8 u_crc (
    .crc_in (crc_q),
    .data   (state_q == DATA ? tx_data_fifo_din : 8'h00),
    .crc_out(crc_next)
  );
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    dcnt_d = dcnt_q;
    len_d = len_q;
    rd_left_d = rd_left_q;
    ptr_rd_d = 1'b0;
    data_rd_d = data_rd_q;
    txd_d = 8'h00;
    en_d = 1'b0;
    crc_d = crc_q;
    frame_cnt_d = frame_cnt_q;
    // data reads run on their own countdown so they can lead the SFD by one cycle
    if (data_rd_q) begin
      rd_left_d = rd_left_q - 11'd1;
      data_rd_d = rd_left_q != 11'd1;
    end
    case (state_q)
      IDLE: if (!tx_ptr_fifo_empty) begin
        state_d = PTR_RD;
        ptr_rd_d = 1'b1;
      end
      PTR_RD: state_d = PTR_WAIT;
      PTR_WAIT: begin
        len_d = tx_ptr_fifo_din[10:0];
        if (tx_ptr_fifo_din[10:0] == 11'd0) state_d = IDLE;
        else begin
          state_d = PREAMBLE;
          cnt_d = 11'd1;
          txd_d = PREAMBLE_BYTE;
          en_d = 1'b1;
          crc_d = CRC_INIT;
          dcnt_d = 11'd0;
          if (PREAMBLE_LEN == 1) begin
            data_rd_d = 1'b1;
            rd_left_d = tx_ptr_fifo_din[10:0];
          end
        end
      end
      PREAMBLE: begin
        en_d = 1'b1;
        if (cnt_q == 11'(PREAMBLE_LEN)) begin
          txd_d = SFD_BYTE;
          state_d = DATA;
        end else begin
          txd_d = PREAMBLE_BYTE;
          cnt_d = cnt_q + 11'd1;
          if (cnt_q == 11'(PREAMBLE_LEN - 1)) begin
            data_rd_d = 1'b1;
            rd_left_d = len_q;
          end
        end
      end
      DATA: begin
        en_d = 1'b1;
        txd_d = tx_data_fifo_din;
        crc_d = crc_next;
        dcnt_d = dcnt_q + 11'd1;
        cnt_d = 11'd0;
        if (dcnt_q == len_q - 11'd1)
`ifdef MAC_TX_PAD_EN
          state_d = (len_q < 11'(MIN_FRAME_LEN)) ? PAD : FCS;
`else
          state_d = FCS;
`endif
      end
`ifdef MAC_TX_PAD_EN
      PAD: begin
        en_d = 1'b1;
        crc_d = crc_next;
        dcnt_d = dcnt_q + 11'd1;
        if (dcnt_q == 11'(MIN_FRAME_LEN - 1)) state_d = FCS;
      end
`endif
      FCS: begin
        en_d = 1'b1;
        txd_d = ~crc_q[7:0];
        crc_d = {8'h00, crc_q[31:8]};
        cnt_d = cnt_q + 11'd1;
        if (cnt_q == 11'd3) begin
          state_d = GAP;
          cnt_d = 11'd0;
          crc_d = CRC_INIT;
          frame_cnt_d = frame_cnt_q + 16'd1;
        end
      end
      // the pointer fetch adds two more idle wire cycles, so GAP is shortened to keep IFG exact
      GAP: if (cnt_q == 11'(IFG - 3)) state_d = IDLE;
           else cnt_d = cnt_q + 11'd1;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      dcnt_q <= '0;
      len_q <= '0;
      rd_left_q <= '0;
      ptr_rd_q <= 1'b0;
      data_rd_q <= 1'b0;
      txd_q <= '0;
      en_q <= 1'b0;
      crc_q <= CRC_INIT;
      frame_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      dcnt_q <= dcnt_d;
      len_q <= len_d;
      rd_left_q <= rd_left_d;
      ptr_rd_q <= ptr_rd_d;
      data_rd_q <= data_rd_d;
      txd_q <= txd_d;
      en_q <= en_d;
      crc_q <= crc_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end
  assign tx_ptr_fifo_rd = ptr_rd_q;
  assign tx_data_fifo_rd = data_rd_q;
  assign gmii_txd = txd_q;
  assign gmii_tx_en = en_q;
  assign tx_frame_cnt = frame_cnt_q;
endmodule

// File: tb/tb_mac_tx.sv
// tb_mac_tx: scoreboard bench for mac_tx with behavioural non-FWFT pointer and data FIFOs.
module tb_mac_tx;
  typedef logic [7:0] bq_t[$];
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic ptr_empty, ptr_rd, data_rd, en;
  logic [15:0] ptr_dout = '0, fcnt;
  logic [7:0] data_dout = '0, txd;
  logic [15:0] ptr_mem[64];
  logic [7:0] data_mem[8192];
  int ptr_wr = 0, ptr_ri = 0, data_wr = 0, data_ri = 0;
  int tests = 0, fails = 0;
  bq_t exp_q, rx_q;
  logic en_prev = 1'b0;
  int low_run = 0, burst = 0, last_burst = 0, last_gap = 0, rises = 0, rd_total = 0;

  mac_tx dut (
    .clk(clk), .rst(rst),
    .tx_ptr_fifo_empty(ptr_empty), .tx_ptr_fifo_rd(ptr_rd), .tx_ptr_fifo_din(ptr_dout),
    .tx_data_fifo_rd(data_rd), .tx_data_fifo_din(data_dout),
    .gmii_txd(txd), .gmii_tx_en(en), .tx_frame_cnt(fcnt)
  );

  assign ptr_empty = (ptr_wr == ptr_ri);
  always @(posedge clk or posedge rst)
    if (rst) begin ptr_ri <= ptr_wr; ptr_dout <= '0; end
    else if (ptr_rd) begin ptr_dout <= ptr_mem[ptr_ri % 64]; ptr_ri <= ptr_ri + 1; end
  always @(posedge clk or posedge rst)
    if (rst) begin data_ri <= data_wr; data_dout <= '0; end
    else if (data_rd) begin data_dout <= data_mem[data_ri % 8192]; data_ri <= data_ri + 1; end

  always @(negedge clk) begin
    if (en) begin
      rx_q.push_back(txd);
      low_run <= 0;
      burst <= en_prev ? burst + 1 : 1;
      if (!en_prev) begin last_gap <= low_run; rises <= rises + 1; end
    end else begin
      low_run <= low_run + 1;
      if (en_prev) last_burst <= burst;
    end
    en_prev <= en;
    if (data_rd) rd_total <= rd_total + 1;
  end

  function automatic logic [31:0] crc_ref(input bq_t b);
    logic [31:0] c = 32'hFFFF_FFFF;
    foreach (b[i]) begin
      c ^= {24'h0, b[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return ~c;
  endfunction

  function automatic bq_t mk(input int n, input int seed);
    bq_t q;
    for (int i = 0; i < n; i++) q.push_back(8'(i * 7 + seed));
    return q;
  endfunction

  task automatic push_frame(input bq_t pay);
    bq_t fr;
    logic [31:0] c;
    fr = pay;
    @(negedge clk);
    foreach (pay[i]) begin data_mem[data_wr % 8192] = pay[i]; data_wr++; end
    ptr_mem[ptr_wr % 64] = {5'b10110, 11'(pay.size())};
    ptr_wr++;
    if (pay.size() > 0) begin
`ifdef MAC_TX_PAD_EN
      while (fr.size() < 60) fr.push_back(8'h00);
`endif
      c = crc_ref(fr);
      repeat (7) exp_q.push_back(8'h55);
      exp_q.push_back(8'hD5);
      foreach (fr[i]) exp_q.push_back(fr[i]);
      for (int i = 0; i < 4; i++) exp_q.push_back(c[8*i +: 8]);
    end
  endtask

  task automatic wait_drain(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      @(posedge clk);
      if (rx_q.size() >= exp_q.size() && low_run > 20 && ptr_empty) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests++; if (en !== 1'b0) begin fails++; $display("FAIL reset_en: got %b want 0", en); end
    tests++; if (txd !== 8'h00) begin fails++; $display("FAIL reset_txd: got %h want 00", txd); end
    tests++; if (ptr_rd !== 1'b0) begin fails++; $display("FAIL reset_ptr_rd: got %b want 0", ptr_rd); end
    tests++; if (data_rd !== 1'b0) begin fails++; $display("FAIL reset_data_rd: got %b want 0", data_rd); end
    tests++; if (fcnt !== 16'h0) begin fails++; $display("FAIL reset_fcnt: got %h want 0", fcnt); end
    rst = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_crc_vector;
    bq_t p;
    bit ok;
    int rd0, n, err;
    logic [31:0] fcs;
    logic [7:0] a, e;
    for (int i = 0; i < 9; i++) p.push_back(8'(8'h31 + i));
    rd0 = rd_total;
    push_frame(p);
    wait_drain(ok);
    tests++; if (!ok) begin fails++; $display("FAIL crc_timeout: got %0d bytes want %0d", rx_q.size(), exp_q.size()); end
    n = rx_q.size();
`ifndef MAC_TX_PAD_EN
    fcs = (n >= 4) ? {rx_q[n-1], rx_q[n-2], rx_q[n-3], rx_q[n-4]} : 32'h0;
    tests++; if (fcs !== 32'hCBF4_3926) begin fails++; $display("FAIL crc_fcs: got %h want cbf43926", fcs); end
    tests++; if (last_burst !== 21) begin fails++; $display("FAIL crc_burst: got %0d want 21", last_burst); end
`else
    tests++; if (last_burst !== 72) begin fails++; $display("FAIL crc_burst: got %0d want 72", last_burst); end
`endif
    tests++; if (n !== exp_q.size()) begin fails++; $display("FAIL crc_len: got %0d want %0d", n, exp_q.size()); end
    err = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
      if (a !== e) err++;
    end
    rx_q.delete();
    tests++; if (err != 0) begin fails++; $display("FAIL crc_stream: %0d byte errors want 0", err); end
    tests++; if (rd_total - rd0 !== 9) begin fails++; $display("FAIL crc_rd: got %0d want 9", rd_total - rd0); end
    tests++; if (fcnt !== 16'd1) begin fails++; $display("FAIL crc_fcnt: got %0d want 1", fcnt); end
  endtask

  task automatic test_len60;
    bit ok;
    int err;
    logic [15:0] f0;
    logic [7:0] a, e;
    f0 = fcnt;
    push_frame(mk(60, 11));
    wait_drain(ok);
    tests++; if (!ok) begin fails++; $display("FAIL len60_timeout: got %0d bytes want %0d", rx_q.size(), exp_q.size()); end
    tests++; if (last_burst !== 72) begin fails++; $display("FAIL len60_burst: got %0d want 72", last_burst); end
    err = (rx_q.size() == exp_q.size()) ? 0 : 1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
      if (a !== e) err++;
    end
    rx_q.delete();
    tests++; if (err != 0) begin fails++; $display("FAIL len60_stream: %0d errors want 0", err); end
    tests++; if (fcnt !== 16'(f0 + 1)) begin fails++; $display("FAIL len60_fcnt: got %0d want %0d", fcnt, f0 + 1); end
  endtask

  task automatic test_back_to_back;
    bit ok;
    int err, rd0;
    logic [15:0] f0;
    logic [7:0] a, e;
    f0 = fcnt; rd0 = rd_total;
    push_frame(mk(30, 2));
    push_frame(mk(45, 77));
    wait_drain(ok);
    tests++; if (!ok) begin fails++; $display("FAIL b2b_timeout: got %0d bytes want %0d", rx_q.size(), exp_q.size()); end
    tests++; if (last_gap !== 12) begin fails++; $display("FAIL b2b_gap: got %0d want 12", last_gap); end
    tests++; if (rd_total - rd0 !== 75) begin fails++; $display("FAIL b2b_rd: got %0d want 75", rd_total - rd0); end
    err = (rx_q.size() == exp_q.size()) ? 0 : 1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
      if (a !== e) err++;
    end
    rx_q.delete();
    tests++; if (err != 0) begin fails++; $display("FAIL b2b_stream: %0d errors want 0", err); end
    tests++; if (fcnt !== 16'(f0 + 2)) begin fails++; $display("FAIL b2b_fcnt: got %0d want %0d", fcnt, f0 + 2); end
  endtask

  task automatic test_zero_len;
    bq_t z;
    bit ok;
    int err, rd0, r0;
    logic [15:0] f0;
    logic [7:0] a, e;
    f0 = fcnt; rd0 = rd_total; r0 = rises;
    push_frame(z);
    push_frame(mk(64, 40));
    wait_drain(ok);
    tests++; if (!ok) begin fails++; $display("FAIL zero_timeout: got %0d bytes want %0d", rx_q.size(), exp_q.size()); end
    tests++; if (rises - r0 !== 1) begin fails++; $display("FAIL zero_bursts: got %0d want 1", rises - r0); end
    tests++; if (rd_total - rd0 !== 64) begin fails++; $display("FAIL zero_rd: got %0d want 64", rd_total - rd0); end
    tests++; if (fcnt !== 16'(f0 + 1)) begin fails++; $display("FAIL zero_fcnt: got %0d want %0d", fcnt, f0 + 1); end
    err = (rx_q.size() == exp_q.size()) ? 0 : 1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
      if (a !== e) err++;
    end
    rx_q.delete();
    tests++; if (err != 0) begin fails++; $display("FAIL zero_stream: %0d errors want 0", err); end
  endtask

  task automatic test_pad;
    bit ok;
    int err, n;
    logic [7:0] a, e;
    push_frame(mk(20, 5));
    wait_drain(ok);
    tests++; if (!ok) begin fails++; $display("FAIL pad_timeout: got %0d bytes want %0d", rx_q.size(), exp_q.size()); end
    n = rx_q.size();
`ifdef MAC_TX_PAD_EN
    tests++; if (last_burst !== 72) begin fails++; $display("FAIL pad_burst: got %0d want 72", last_burst); end
    err = 0;
    for (int i = 28; i < 68 && i < n; i++) if (rx_q[i] !== 8'h00) err++;
    tests++; if (err != 0 || n < 68) begin fails++; $display("FAIL pad_zeros: %0d nonzero of %0d bytes", err, n); end
`else
    tests++; if (last_burst !== 32) begin fails++; $display("FAIL pad_burst: got %0d want 32", last_burst); end
`endif
    err = (n == exp_q.size()) ? 0 : 1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
      if (a !== e) err++;
    end
    rx_q.delete();
    tests++; if (err != 0) begin fails++; $display("FAIL pad_stream: %0d errors want 0", err); end
  endtask

  task automatic test_reset_mid;
    bit ok;
    int err, r1;
    logic [7:0] a, e;
    push_frame(mk(100, 3));
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk);
      if (rx_q.size() >= 30) begin ok = 1'b1; break; end
    end
    tests++; if (!ok) begin fails++; $display("FAIL mid_timeout: got %0d bytes want 30", rx_q.size()); end
    #2 rst = 1'b1;
    #1;
    tests++; if (en !== 1'b0) begin fails++; $display("FAIL mid_en: got %b want 0", en); end
    tests++; if ({txd, ptr_rd, data_rd, fcnt} !== 26'h0) begin
      fails++; $display("FAIL mid_outputs: txd=%h ptr_rd=%b data_rd=%b fcnt=%0d want all 0", txd, ptr_rd, data_rd, fcnt);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rx_q.delete(); exp_q.delete();
    r1 = rises;
    repeat (30) @(negedge clk);
    tests++; if (rises !== r1 || en !== 1'b0) begin fails++; $display("FAIL mid_resume: got %0d bursts want 0", rises - r1); end
    push_frame(mk(20, 9));
    wait_drain(ok);
    tests++; if (!ok) begin fails++; $display("FAIL mid_new_timeout: got %0d bytes want %0d", rx_q.size(), exp_q.size()); end
    err = (rx_q.size() == exp_q.size()) ? 0 : 1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
      if (a !== e) err++;
    end
    rx_q.delete();
    tests++; if (err != 0) begin fails++; $display("FAIL mid_new_stream: %0d errors want 0", err); end
    tests++; if (fcnt !== 16'd1) begin fails++; $display("FAIL mid_fcnt: got %0d want 1", fcnt); end
  endtask

  initial begin
    test_reset;
    test_crc_vector;
    test_len60;
    test_back_to_back;
    test_zero_len;
    test_pad;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
